// File: rtl/ip_timer_pkg.sv
// Shared definitions for the ip_timer peripheral: register map, control/status
// bit positions and reset constants.
package ip_timer_pkg;

  localparam logic [5:0] ADDR_CTRL   = 6'h00;
  localparam logic [5:0] ADDR_STATUS = 6'h01;
  localparam logic [5:0] ADDR_IRQ_EN = 6'h02;
  localparam logic [5:0] ADDR_CNT_L  = 6'h04;
  localparam logic [5:0] ADDR_CNT_H  = 6'h05;
  localparam logic [5:0] ADDR_TOP_L  = 6'h06;
  localparam logic [5:0] ADDR_TOP_H  = 6'h07;
  localparam logic [5:0] ADDR_CMP0_L = 6'h08;
  localparam logic [5:0] ADDR_CMP0_H = 6'h09;
  localparam logic [5:0] ADDR_CMP1_L = 6'h0A;
  localparam logic [5:0] ADDR_CMP1_H = 6'h0B;

  localparam int CTRL_EN        = 0;
  localparam int CTRL_CLK_SEL   = 1;
  localparam int CTRL_TRIG_EN   = 2;
  localparam int CTRL_ONE_SHOT  = 3;
  localparam int CTRL_OUT_EN    = 4;
  localparam int CTRL_PRESC_LSB = 5;

  localparam int STAT_OVF  = 0;
  localparam int STAT_CMP0 = 1;
  localparam int STAT_CMP1 = 2;

  localparam logic [15:0] TOP_RESET = 16'hFFFF;

  typedef enum logic {
    SRC_PRESC = 1'b0,
    SRC_EXT   = 1'b1
  } clk_src_e;

  // Low PRESC bits of the divider that must all be set for a tick (2^PRESC - 1).
  function automatic logic [7:0] presc_mask(input logic [2:0] presc);
    logic [7:0] one_hot;
    one_hot = 8'd1 << presc;
    return one_hot - 8'd1;
  endfunction

endpackage

// File: rtl/ip_timer_sync_edge.sv
// Multi-stage synchroniser for an asynchronous input followed by a registered
// rising-edge detector producing a one-cycle pulse in the clk domain.
module ip_timer_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic rise_pulse
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // SYNC_STAGES must be at least 2; the pulse appears SYNC_STAGES+1 cycles after the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q     <= '0;
      prev_q     <= 1'b0;
      rise_pulse <= 1'b0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], async_in};
      prev_q     <= sync_q[SYNC_STAGES-1];
      rise_pulse <= sync_q[SYNC_STAGES-1] & ~prev_q;
    end
  end

endmodule

// File: rtl/ip_timer.sv
// 16-bit general-purpose timer peripheral on an 8-bit register bus: prescaled or
// external counting to TOP, two compare channels, level interrupts and PWM output.
module ip_timer
  import ip_timer_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] addr,
  input  logic       wr_en,
  input  logic       mod_en,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       overflow_int,
  output logic       comp_0_match_int,
  output logic       comp_1_match_int,
  output logic       timer_out,
  input  logic       trigger,
  input  logic       clk_ext
);

  logic [7:0]  ctrl_q;
  logic [2:0]  status_q;
  logic [2:0]  irq_en_q;
  logic [15:0] cnt_q;
  logic [15:0] top_q;
  logic [15:0] cmp0_q;
  logic [15:0] cmp1_q;
  logic [7:0]  cnt_shadow_q;
  logic [7:0]  div_q;
  logic        run_q;
  logic        tout_q;

  logic        wr_acc;
  logic        rd_acc;
  logic        en;
  logic        trig_en;
  logic        one_shot;
  logic [2:0]  presc;
  logic [7:0]  mask;
  clk_src_e    src;
  logic        run;
  logic        presc_tick;
  logic        ext_rise;
  logic        trig_rise;
  logic        tick;
  logic        ovf_evt;
  logic        cmp0_evt;
  logic        cmp1_evt;
  logic        oneshot_stop;
  logic [2:0]  status_set;
  logic [2:0]  status_clr;

  ip_timer_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ext (
    .clk        (clk),
    .rst        (rst),
    .async_in   (clk_ext),
    .rise_pulse (ext_rise)
  );

  ip_timer_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_trig (
    .clk        (clk),
    .rst        (rst),
    .async_in   (trigger),
    .rise_pulse (trig_rise)
  );

  assign wr_acc   = mod_en & wr_en;
  assign rd_acc   = mod_en & ~wr_en;
  assign en       = ctrl_q[CTRL_EN];
  assign trig_en  = ctrl_q[CTRL_TRIG_EN];
  assign one_shot = ctrl_q[CTRL_ONE_SHOT];
  assign presc    = ctrl_q[CTRL_PRESC_LSB +: 3];
  assign src      = clk_src_e'(ctrl_q[CTRL_CLK_SEL]);
  assign mask     = presc_mask(presc);

  // In trigger mode the armed flag gates counting, but EN always has the final say.
  assign run        = en & (trig_en ? run_q : 1'b1);
  assign presc_tick = (div_q & mask) == mask;
  assign tick       = run & ((src == SRC_EXT) ? ext_rise : presc_tick);

  assign ovf_evt      = tick & (cnt_q == top_q);
  assign cmp0_evt     = tick & (cnt_q == cmp0_q);
  assign cmp1_evt     = tick & (cnt_q == cmp1_q);
  assign oneshot_stop = ovf_evt & one_shot;

  assign status_set = {cmp1_evt, cmp0_evt, ovf_evt};
  assign status_clr = (wr_acc && addr == ADDR_STATUS) ? wdata[2:0] : 3'b000;

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q <= 8'h00;
    end else if (wr_acc && addr == ADDR_CTRL) begin
      ctrl_q <= wdata;
    end else if (oneshot_stop) begin
      ctrl_q[CTRL_EN] <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || !en || oneshot_stop) begin
      run_q <= 1'b0;
    end else if (trig_en && trig_rise) begin
      run_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || !run) begin
      div_q <= 8'h00;
    end else begin
      div_q <= div_q + 8'd1;
    end
  end

  // Hardware-set is OR-ed in after the W1C mask so a same-cycle event survives the clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      status_q <= 3'b000;
    end else begin
      status_q <= (status_q & ~status_clr) | status_set;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      irq_en_q <= 3'b000;
      top_q    <= TOP_RESET;
      cmp0_q   <= 16'h0000;
      cmp1_q   <= 16'h0000;
    end else if (wr_acc) begin
      case (addr)
        ADDR_IRQ_EN: irq_en_q     <= wdata[2:0];
        ADDR_TOP_L:  top_q[7:0]   <= wdata;
        ADDR_TOP_H:  top_q[15:8]  <= wdata;
        ADDR_CMP0_L: cmp0_q[7:0]  <= wdata;
        ADDR_CMP0_H: cmp0_q[15:8] <= wdata;
        ADDR_CMP1_L: cmp1_q[7:0]  <= wdata;
        ADDR_CMP1_H: cmp1_q[15:8] <= wdata;
        default: ;
      endcase
    end
  end

  // A CPU byte write to the count takes priority over that cycle's tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 16'h0000;
    end else if (wr_acc && addr == ADDR_CNT_L) begin
      cnt_q[7:0] <= wdata;
    end else if (wr_acc && addr == ADDR_CNT_H) begin
      cnt_q[15:8] <= wdata;
    end else if (tick) begin
      cnt_q <= (cnt_q == top_q) ? 16'h0000 : cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_shadow_q <= 8'h00;
    end else if (rd_acc && addr == ADDR_CNT_L) begin
      cnt_shadow_q <= cnt_q[15:8];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tout_q <= 1'b0;
    end else if (ovf_evt) begin
      tout_q <= 1'b1;
    end else if (cmp0_evt) begin
      tout_q <= 1'b0;
    end
  end

  always_comb begin
    rdata = 8'h00;
    if (rd_acc) begin
      case (addr)
        ADDR_CTRL:   rdata = ctrl_q;
        ADDR_STATUS: rdata = {5'b00000, status_q};
        ADDR_IRQ_EN: rdata = {5'b00000, irq_en_q};
        ADDR_CNT_L:  rdata = cnt_q[7:0];
        ADDR_CNT_H:  rdata = cnt_shadow_q;
        ADDR_TOP_L:  rdata = top_q[7:0];
        ADDR_TOP_H:  rdata = top_q[15:8];
        ADDR_CMP0_L: rdata = cmp0_q[7:0];
        ADDR_CMP0_H: rdata = cmp0_q[15:8];
        ADDR_CMP1_L: rdata = cmp1_q[7:0];
        ADDR_CMP1_H: rdata = cmp1_q[15:8];
        default:     rdata = 8'h00;
      endcase
    end
  end

  assign overflow_int     = status_q[STAT_OVF]  & irq_en_q[0];
  assign comp_0_match_int = status_q[STAT_CMP0] & irq_en_q[1];
  assign comp_1_match_int = status_q[STAT_CMP1] & irq_en_q[2];
  assign timer_out        = tout_q & ctrl_q[CTRL_OUT_EN];

endmodule

// File: tb/tb_ip_timer.sv
// Scoreboard bench for ip_timer: directed corner cases plus randomized counting
// rounds predicted from elapsed cycles and the prescale ratio.
module tb_ip_timer;
  import ip_timer_pkg::*;

  localparam int SYNC = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] addr;
  logic       wr_en;
  logic       mod_en;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic       overflow_int;
  logic       comp_0_match_int;
  logic       comp_1_match_int;
  logic       timer_out;
  logic       trigger;
  logic       clk_ext;

  always #5 clk = ~clk;

  ip_timer #(.SYNC_STAGES(SYNC)) dut (
    .clk              (clk),
    .rst              (rst),
    .addr             (addr),
    .wr_en            (wr_en),
    .mod_en           (mod_en),
    .wdata            (wdata),
    .rdata            (rdata),
    .overflow_int     (overflow_int),
    .comp_0_match_int (comp_0_match_int),
    .comp_1_match_int (comp_1_match_int),
    .timer_out        (timer_out),
    .trigger          (trigger),
    .clk_ext          (clk_ext)
  );

  typedef struct {
    int sel;
    int lo;
    int hi;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];
  logic  chk_pending = 1'b0;
  int    n_tests = 0;
  int    n_fail  = 0;
  int    cyc     = 0;

  int m_cnt, m_top, m_cmp0, m_cmp1, m_status, m_tout;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: samples mid-cycle whenever stimulus flags a pending observation.
  initial begin : monitor
    exp_t  e;
    string t;
    int    act;
    forever begin
      @(negedge clk);
      #1;
      if (chk_pending) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("[TB] FAIL scoreboard_empty: actual=no entry required=entry");
        end else begin
          e = exp_q.pop_front();
          t = tag_q.pop_front();
          case (e.sel)
            0:       act = int'(rdata);
            1:       act = int'(overflow_int);
            2:       act = int'(comp_0_match_int);
            3:       act = int'(comp_1_match_int);
            4:       act = int'(timer_out);
            default: act = -1;
          endcase
          if (act < e.lo || act > e.hi) begin
            n_fail++;
            $display("[TB] FAIL %s: actual=0x%0h required=0x%0h..0x%0h", t, act, e.lo, e.hi);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic push_exp(input int sel, input int lo, input int hi, input string tag);
    exp_t e;
    e.sel = sel;
    e.lo  = lo;
    e.hi  = hi;
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  // All bus tasks start and end on a falling edge, one clk cycle per access.
  task automatic apply_stimulus(input logic [5:0] a, input logic [7:0] d);
    mod_en = 1'b1; wr_en = 1'b1; addr = a; wdata = d;
    @(negedge clk);
    mod_en = 1'b0; wr_en = 1'b0;
  endtask

  task automatic write16(input logic [5:0] a_lo, input int v);
    apply_stimulus(a_lo, 8'(v));
    apply_stimulus(a_lo + 6'd1, 8'(v >> 8));
  endtask

  task automatic check_output(input logic [5:0] a, input int lo, input int hi, input string tag);
    mod_en = 1'b1; wr_en = 1'b0; addr = a;
    push_exp(0, lo, hi, tag);
    chk_pending = 1'b1;
    @(negedge clk);
    mod_en = 1'b0; chk_pending = 1'b0;
  endtask

  task automatic check_pin(input int sel, input int v, input string tag);
    push_exp(sel, v, v, tag);
    chk_pending = 1'b1;
    @(negedge clk);
    chk_pending = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic ext_pulses(input int n);
    repeat (n) begin
      clk_ext = 1'b1;
      idle(6);
      clk_ext = 1'b0;
      idle(6);
    end
  endtask

  // Reference: applies the counting rules once per tick.
  task automatic model_ticks(input int n);
    int pre;
    for (int i = 0; i < n; i++) begin
      pre = m_cnt;
      m_cnt = (pre == m_top) ? 0 : (pre + 1) % 65536;
      if (pre == m_top)  m_status |= 1;
      if (pre == m_cmp0) m_status |= 2;
      if (pre == m_cmp1) m_status |= 4;
      if (pre == m_top)       m_tout = 1;
      else if (pre == m_cmp0) m_tout = 0;
    end
  endtask

  initial begin : stimulus
    int a, b, t0, lo, hi;
    rst = 1'b1; mod_en = 1'b0; wr_en = 1'b0; addr = '0; wdata = '0;
    trigger = 1'b0; clk_ext = 1'b0;
    idle(3);
    rst = 1'b0;

    check_output(ADDR_CTRL,   0, 0, "rst_ctrl");
    check_output(ADDR_STATUS, 0, 0, "rst_status");
    check_output(ADDR_IRQ_EN, 0, 0, "rst_irq_en");
    check_output(ADDR_CNT_L,  0, 0, "rst_cnt_l");
    check_output(ADDR_CNT_H,  0, 0, "rst_cnt_h");
    check_output(ADDR_TOP_L,  8'hFF, 8'hFF, "rst_top_l");
    check_output(ADDR_TOP_H,  8'hFF, 8'hFF, "rst_top_h");
    check_output(ADDR_CMP0_L, 0, 0, "rst_cmp0_l");
    check_output(ADDR_CMP0_H, 0, 0, "rst_cmp0_h");
    check_output(ADDR_CMP1_L, 0, 0, "rst_cmp1_l");
    check_output(ADDR_CMP1_H, 0, 0, "rst_cmp1_h");
    check_pin(1, 0, "rst_ovf_int");
    check_pin(2, 0, "rst_cmp0_int");
    check_pin(3, 0, "rst_cmp1_int");
    check_pin(4, 0, "rst_timer_out");
    apply_stimulus(6'h0C, 8'h5A);
    check_output(6'h0C, 0, 0, "unmapped_read");
    check_output(6'h3F, 0, 0, "unmapped_top_addr");

    // CMP0 equal to TOP on a one-shot wrap: overflow must win the output.
    write16(ADDR_TOP_L, 5);
    write16(ADDR_CMP0_L, 5);
    write16(ADDR_CNT_L, 5);
    apply_stimulus(ADDR_CTRL, 8'h19);
    idle(2);
    check_pin(4, 1, "cmp0_eq_top_out");
    check_output(ADDR_STATUS, 8'h03, 8'h03, "cmp0_eq_top_status");
    check_output(ADDR_CTRL, 8'h18, 8'h18, "oneshot_en_clear");
    check_output(ADDR_CNT_L, 0, 0, "oneshot_cnt_wrap");

    // W1C landing on the same edge as an overflow (TOP=0 one-shot).
    apply_stimulus(ADDR_STATUS, 8'h07);
    check_output(ADDR_STATUS, 0, 0, "w1c_clear");
    write16(ADDR_TOP_L, 0);
    apply_stimulus(ADDR_CTRL, 8'h09);
    apply_stimulus(ADDR_STATUS, 8'h01);
    check_output(ADDR_STATUS, 8'h05, 8'h05, "w1c_vs_ovf");
    check_output(ADDR_CTRL, 8'h08, 8'h08, "top0_oneshot_ctrl");
    check_pin(4, 0, "out_en_gates_pin");

    // CNT_L write colliding with a running tick.
    apply_stimulus(ADDR_STATUS, 8'h07);
    write16(ADDR_TOP_L, 16'hFFFF);
    write16(ADDR_CNT_L, 16'h0010);
    apply_stimulus(ADDR_CTRL, 8'h01);
    apply_stimulus(ADDR_CNT_L, 8'h20);
    apply_stimulus(ADDR_CTRL, 8'h00);
    check_output(ADDR_CNT_L, 8'h21, 8'h21, "cnt_write_wins");
    check_output(ADDR_CNT_H, 0, 0, "cnt_write_high_holds");
    apply_stimulus(ADDR_CTRL, 8'h01);
    a = cyc;
    idle(20);
    apply_stimulus(ADDR_CTRL, 8'h00);
    b = cyc;
    check_output(ADDR_CNT_L, 8'h21 + (b - a), 8'h21 + (b - a), "count_continues");

    // Coherent read: CNT_H returns the byte captured at the CNT_L read.
    apply_stimulus(ADDR_CNT_H, 8'h12);
    apply_stimulus(ADDR_CNT_L, 8'h34);
    check_output(ADDR_CNT_L, 8'h34, 8'h34, "shadow_cnt_l");
    apply_stimulus(ADDR_CNT_H, 8'h56);
    check_output(ADDR_CNT_H, 8'h12, 8'h12, "shadow_cnt_h");
    check_output(ADDR_CNT_L, 8'h34, 8'h34, "shadow_cnt_l2");
    check_output(ADDR_CNT_H, 8'h56, 8'h56, "shadow_cnt_h2");

    // External clock, one-shot with TOP=4 (CMP1=0 matches the first tick).
    apply_stimulus(ADDR_STATUS, 8'h07);
    write16(ADDR_TOP_L, 4);
    write16(ADDR_CNT_L, 0);
    apply_stimulus(ADDR_CTRL, 8'h0B);
    ext_pulses(3);
    idle(4);
    check_output(ADDR_CNT_L, 3, 3, "ext_three_edges");
    ext_pulses(2);
    idle(4);
    check_output(ADDR_STATUS, 8'h05, 8'h05, "ext_ovf_status");
    check_output(ADDR_CTRL, 8'h0A, 8'h0A, "ext_oneshot_ctrl");
    check_output(ADDR_CNT_L, 0, 0, "ext_cnt_wrapped");
    ext_pulses(3);
    idle(4);
    check_output(ADDR_CNT_L, 0, 0, "ext_stopped");

    // Trigger start: armed but idle until a synchronised trigger edge.
    apply_stimulus(ADDR_STATUS, 8'h07);
    write16(ADDR_TOP_L, 16'hFFFF);
    write16(ADDR_CNT_L, 0);
    apply_stimulus(ADDR_CTRL, 8'h05);
    idle(20);
    check_output(ADDR_CNT_L, 0, 0, "trig_wait_cnt");
    trigger = 1'b1;
    t0 = cyc;
    idle(3);
    trigger = 1'b0;
    idle(25);
    apply_stimulus(ADDR_CTRL, 8'h04);
    b = cyc;
    lo = b - t0 - (SYNC + 4);
    hi = b - t0 - SYNC;
    check_output(ADDR_CNT_L, lo, hi, "trig_counted");
    idle(30);
    check_output(ADDR_CNT_L, lo, hi, "trig_en_clear_stops");
    apply_stimulus(ADDR_CTRL, 8'h05);
    idle(10);
    check_output(ADDR_CNT_L, lo, hi, "trig_rearm_needs_edge");

    // Reset while counting.
    apply_stimulus(ADDR_CTRL, 8'h11);
    idle(10);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    check_output(ADDR_CTRL, 0, 0, "midrst_ctrl");
    check_output(ADDR_STATUS, 0, 0, "midrst_status");
    check_output(ADDR_CNT_L, 0, 0, "midrst_cnt_l");
    check_output(ADDR_TOP_H, 8'hFF, 8'hFF, "midrst_top_h");
    check_output(ADDR_CMP0_L, 0, 0, "midrst_cmp0_l");
    check_pin(4, 0, "midrst_timer_out");

    m_cnt = 0; m_top = 16'hFFFF; m_cmp0 = 0; m_cmp1 = 0; m_status = 0; m_tout = 0;

    // Randomized rounds: ticks follow from elapsed cycles divided by 2^PRESC.
    for (int r = 0; r < 12; r++) begin
      int         top, c0, c1, cnt0, wait_c, ticks, clr;
      logic [2:0] presc, irq;
      logic       oe;
      top    = (r == 0) ? 0 : int'($urandom_range(40, 0));
      c0     = int'($urandom_range(top + 2, 0));
      c1     = int'($urandom_range(top + 2, 0));
      cnt0   = int'($urandom_range(top, 0));
      presc  = 3'($urandom_range(3, 0));
      oe     = 1'($urandom_range(1, 0));
      irq    = 3'($urandom_range(7, 0));
      wait_c = int'($urandom_range(80, 10));
      write16(ADDR_TOP_L, top);
      write16(ADDR_CMP0_L, c0);
      write16(ADDR_CMP1_L, c1);
      write16(ADDR_CNT_L, cnt0);
      apply_stimulus(ADDR_IRQ_EN, {5'b00000, irq});
      apply_stimulus(ADDR_STATUS, 8'h07);
      m_top = top; m_cmp0 = c0; m_cmp1 = c1; m_cnt = cnt0; m_status = 0;
      apply_stimulus(ADDR_CTRL, {presc, oe, 4'b0001});
      a = cyc;
      idle(wait_c);
      apply_stimulus(ADDR_CTRL, {presc, oe, 4'b0000});
      b = cyc;
      ticks = (b - a) >> presc;
      model_ticks(ticks);
      check_output(ADDR_STATUS, m_status, m_status, "rnd_status");
      check_output(ADDR_CNT_L, m_cnt & 255, m_cnt & 255, "rnd_cnt_l");
      check_output(ADDR_CNT_H, m_cnt >> 8, m_cnt >> 8, "rnd_cnt_h");
      check_pin(1, (m_status & 1) & int'(irq[0]), "rnd_ovf_int");
      check_pin(2, ((m_status >> 1) & 1) & int'(irq[1]), "rnd_cmp0_int");
      check_pin(3, ((m_status >> 2) & 1) & int'(irq[2]), "rnd_cmp1_int");
      check_pin(4, m_tout & int'(oe), "rnd_timer_out");
      clr = int'($urandom_range(7, 0));
      apply_stimulus(ADDR_STATUS, 8'(clr));
      m_status &= ~clr;
      check_output(ADDR_STATUS, m_status, m_status, "rnd_w1c");
    end

    idle(2);
    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("[TB] FAIL scoreboard_leftover: actual=%0d entries required=0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
